// File: rtl/dau_stream_formatter.sv
// dau_stream_formatter: reads one BCDU register with a single SHR instruction
// and turns the streamed BCD digits into DAU display symbols (minus, leading
// zero suppression, decimal comma, optional fraction-zero trim), buffered in a
// small two-write symbol FIFO. Loopback symbols are forwarded while idle.

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 5
`endif
`ifndef DAU_SYM_INVALID
`define DAU_SYM_INVALID 5'h00
`endif
`ifndef DAU_SYM_COMMA
`define DAU_SYM_COMMA 5'h0C
`endif
`ifndef DAU_SYM_MINUS
`define DAU_SYM_MINUS 5'h0D
`endif
`ifndef BCDU_OP_SHR
`define BCDU_OP_SHR 4'hA
`endif
`ifndef BCDU_NUM_FLAGS
`define BCDU_NUM_FLAGS 4
`endif
`ifndef BCDU_TF
`define BCDU_TF 0
`endif

module dau_stream_formatter #(
  parameter int NUM_DIGITS  = 8,
  parameter int COMMA_WIDTH = $clog2(NUM_DIGITS),
  parameter int FIFO_DEPTH  = NUM_DIGITS + 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_loopback_en,
  input  logic [`DAU_SYM_WIDTH-1:0]  i_lb_symbol,
  input  logic                       i_lb_valid,
  output logic                       o_lb_ready,
  input  logic                       i_stream_start,
  input  logic                       i_sign,
  input  logic [COMMA_WIDTH-1:0]     i_comma,
  input  logic                       i_trim_en,
  input  logic [3:0]                 i_bcdu_addr,
  output logic [15:0]                o_bcdu_instr,
  output logic                       o_bcdu_instr_valid,
  input  logic                       i_bcdu_instr_ready,
  input  logic [3:0]                 i_bcdu_digit,
  input  logic                       i_bcdu_digit_valid,
  input  logic [`BCDU_NUM_FLAGS-1:0] i_bcdu_flags,
  output logic [`DAU_SYM_WIDTH-1:0]  o_symbol,
  output logic                       o_symbol_valid,
  input  logic                       i_symbol_ready,
  output logic                       o_busy,
  output logic                       o_stream_done,
  output logic                       o_err
);

  localparam int SYM_W = `DAU_SYM_WIDTH;
  localparam int DW    = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < NUM_DIGITS + 2) begin : g_depthCheck
    $error("dau_stream_formatter: FIFO_DEPTH must be at least NUM_DIGITS+2");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DRAIN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic              trim_q, trim_d;
  logic [3:0]        addr_q, addr_d;
  logic [DW-1:0]     c_q, c_d;
  logic [DW-1:0]     d_q, d_d;
  logic              gotMsd_q, gotMsd_d;
  logic              err_q, err_d;

  logic [SYM_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, wrPtrNext;
  logic [CW-1:0]     count_q, count_d, freeSlots;

  logic              push0, push1, pop, full, stopEmit;
  logic [SYM_W-1:0]  push0Sym, push1Sym, digitSym;
  logic              digitBad, tfFlag, lbReady, instrValid, unusedFlags;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign digitSym    = {{(SYM_W-4){1'b1}}, i_bcdu_digit};
  assign digitBad    = i_bcdu_digit > 4'd9;
  assign tfFlag      = i_bcdu_flags[`BCDU_TF];
  assign unusedFlags = ^i_bcdu_flags;

  assign full      = count_q == CW'(FIFO_DEPTH);
  assign freeSlots = CW'(FIFO_DEPTH) - count_q;
  assign pop       = (count_q != '0) && i_symbol_ready;
  assign wrPtrNext = ptrInc(wrPtr_q);
  assign wrPtr_d   = push1 ? ptrInc(wrPtrNext) : (push0 ? wrPtrNext : wrPtr_q);
  assign count_d   = count_q + CW'(push0) + CW'(push1) - CW'(pop);

  assign o_symbol           = (count_q != '0) ? mem_q[rdPtr_q] : `DAU_SYM_INVALID;
  assign o_symbol_valid     = count_q != '0;
  assign o_lb_ready         = lbReady;
  assign o_bcdu_instr_valid = instrValid;
  assign o_bcdu_instr       = (state_q == ISSUE) ?
                              {`BCDU_OP_SHR, addr_q, 2'b00, 6'(NUM_DIGITS)} : 16'h0000;
  assign o_busy             = state_q != IDLE;
  assign o_stream_done      = state_q == DONE;
  assign o_err              = err_q;

  // Sequencing and symbol generation: decides what to push this cycle and where to go next.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    trim_d     = trim_q;
    addr_d     = addr_q;
    c_d        = c_q;
    d_d        = d_q;
    gotMsd_d   = gotMsd_q;
    err_d      = err_q;
    push0      = 1'b0;
    push0Sym   = '0;
    push1      = 1'b0;
    push1Sym   = '0;
    lbReady    = 1'b0;
    instrValid = 1'b0;
    stopEmit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_stream_start) begin
          sign_d  = i_sign;
          trim_d  = i_trim_en;
          addr_d  = i_bcdu_addr;
          c_d     = (int'(i_comma) >= NUM_DIGITS) ? DW'(NUM_DIGITS - 1) : DW'(i_comma);
          err_d   = 1'b0;
          state_d = ISSUE;
        end else begin
          lbReady = i_loopback_en && !full;
          if (i_lb_valid && lbReady) begin
            push0    = 1'b1;
            push0Sym = i_lb_symbol;
          end
        end
      end
      ISSUE: begin
        instrValid = freeSlots >= CW'(NUM_DIGITS + 2);
        if (instrValid && i_bcdu_instr_ready) begin
          push0    = sign_q;
          push0Sym = `DAU_SYM_MINUS;
          d_d      = DW'(NUM_DIGITS - 1);
          gotMsd_d = 1'b0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (i_bcdu_digit_valid) begin
          if (digitBad) begin
            push0    = 1'b1;
            push0Sym = `DAU_SYM_INVALID;
            err_d    = 1'b1;
            gotMsd_d = 1'b1;
          end else if (d_q > c_q) begin
            push0    = gotMsd_q || (i_bcdu_digit != 4'd0);
            push0Sym = digitSym;
            if (i_bcdu_digit != 4'd0) gotMsd_d = 1'b1;
          end else if (d_q == c_q) begin
            push0    = 1'b1;
            push0Sym = digitSym;
          end else if (trim_q && (i_bcdu_digit == 4'd0) && !tfFlag) begin
            stopEmit = 1'b1;
          end else begin
            push0    = 1'b1;
            push0Sym = digitSym;
          end
          if ((d_q == c_q) && (c_q != '0)) begin
            if (trim_q && !tfFlag) begin
              stopEmit = 1'b1;
            end else begin
              push1    = 1'b1;
              push1Sym = `DAU_SYM_COMMA;
            end
          end
          d_d = d_q - DW'(1);
          if (d_q == '0) state_d = FLUSH;
          else if (stopEmit) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_bcdu_digit_valid) begin
          d_d = d_q - DW'(1);
          if (d_q == '0) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (count_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: FSM state, latched stream parameters, digit index and error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      trim_q   <= 1'b0;
      addr_q   <= '0;
      c_q      <= '0;
      d_q      <= '0;
      gotMsd_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      trim_q   <= trim_d;
      addr_q   <= addr_d;
      c_q      <= c_d;
      d_q      <= d_d;
      gotMsd_q <= gotMsd_d;
      err_q    <= err_d;
    end
  end

  // Symbol FIFO storage: up to two writes and one read per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push0) mem_q[wrPtr_q] <= push0Sym;
      if (push1) mem_q[wrPtrNext] <= push1Sym;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= pop ? ptrInc(rdPtr_q) : rdPtr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_dau_stream_formatter.sv
// tb_dau_stream_formatter: directed streams against a digit-level model of the
// formatting rules, with a scoreboard that checks every symbol popped.

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 5
`endif
`ifndef DAU_SYM_INVALID
`define DAU_SYM_INVALID 5'h00
`endif
`ifndef DAU_SYM_COMMA
`define DAU_SYM_COMMA 5'h0C
`endif
`ifndef DAU_SYM_MINUS
`define DAU_SYM_MINUS 5'h0D
`endif
`ifndef BCDU_OP_SHR
`define BCDU_OP_SHR 4'hA
`endif
`ifndef BCDU_NUM_FLAGS
`define BCDU_NUM_FLAGS 4
`endif
`ifndef BCDU_TF
`define BCDU_TF 0
`endif

module tb_dau_stream_formatter;

  localparam int ND = 4;
  localparam int SW = `DAU_SYM_WIDTH;
  localparam logic [SW-1:0] MINUS  = `DAU_SYM_MINUS;
  localparam logic [SW-1:0] COMMA  = `DAU_SYM_COMMA;
  localparam logic [SW-1:0] INVSYM = `DAU_SYM_INVALID;

  logic clk = 1'b0;
  logic rstN;
  logic lbEn, lbValid, lbReadyOut;
  logic [SW-1:0] lbSym;
  logic startIn, signIn, trimIn;
  logic [1:0] commaIn;
  logic [3:0] addrIn;
  logic [15:0] instrOut;
  logic instrValidOut, bcduReady;
  logic [3:0] digitIn;
  logic digitValid;
  logic [`BCDU_NUM_FLAGS-1:0] flagsIn;
  logic [SW-1:0] symOut;
  logic symValidOut, symReady, busyOut, doneOut, errOut;

  int passCount = 0;
  int totalCount = 0;
  int doneCount = 0;
  bit checkEn = 1'b0;
  bit expErr = 1'b0;
  bit modelErr = 1'b0;
  logic [SW-1:0] expQ[$];
  logic [SW-1:0] modelQ[$];
  logic [SW-1:0] pinQ[$];

  dau_stream_formatter #(.NUM_DIGITS(ND)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_loopback_en(lbEn), .i_lb_symbol(lbSym), .i_lb_valid(lbValid), .o_lb_ready(lbReadyOut),
    .i_stream_start(startIn), .i_sign(signIn), .i_comma(commaIn), .i_trim_en(trimIn),
    .i_bcdu_addr(addrIn), .o_bcdu_instr(instrOut), .o_bcdu_instr_valid(instrValidOut),
    .i_bcdu_instr_ready(bcduReady), .i_bcdu_digit(digitIn), .i_bcdu_digit_valid(digitValid),
    .i_bcdu_flags(flagsIn), .o_symbol(symOut), .o_symbol_valid(symValidOut),
    .i_symbol_ready(symReady), .o_busy(busyOut), .o_stream_done(doneOut), .o_err(errOut)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [SW-1:0] digSym(input logic [3:0] d);
    return (d > 4'd9) ? INVSYM : {{(SW-4){1'b1}}, d};
  endfunction

  // Formatting rules on whole digit arrays: integer part from the first
  // nonzero digit (units always shown), then comma and fraction, where trim
  // drops trailing zero fraction digits and the comma if nothing is left.
  task automatic buildModel(input logic [15:0] r, input bit sgn, input int c, input bit trim);
    logic [3:0] dg [ND];
    int cc, msd, lowNz;
    modelQ.delete();
    modelErr = 1'b0;
    cc = (c >= ND) ? ND - 1 : c;
    for (int i = 0; i < ND; i++) begin
      dg[i] = r[i*4 +: 4];
      if (dg[i] > 4'd9) modelErr = 1'b1;
    end
    if (sgn) modelQ.push_back(MINUS);
    msd = cc;
    for (int i = cc; i < ND; i++) if (dg[i] != 4'd0) msd = i;
    for (int i = msd; i >= cc; i--) modelQ.push_back(digSym(dg[i]));
    if (cc > 0) begin
      lowNz = trim ? -1 : 0;
      if (trim) for (int i = cc - 1; i >= 0; i--) if (dg[i] != 4'd0) lowNz = i;
      if (lowNz >= 0) begin
        modelQ.push_back(COMMA);
        for (int i = cc - 1; i >= lowNz; i--) modelQ.push_back(digSym(dg[i]));
      end
    end
  endtask

  task automatic pinModel(input string name, input logic [15:0] r, input bit s, input int c, input bit t);
    bit ok;
    buildModel(r, s, c, t);
    ok = (modelQ.size() == pinQ.size());
    if (ok) foreach (pinQ[i]) if (modelQ[i] !== pinQ[i]) ok = 1'b0;
    checkOutput(name, 32'(ok), 32'd1);
  endtask

  // Starts a stream, handshakes the instruction and plays the BCDU digit stream.
  task automatic applyStimulus(input logic [15:0] r, input bit sgn, input logic [1:0] c,
                               input bit trim, input logic [3:0] addr, input int feed,
                               input bit busyStart);
    int budget;
    int idx;
    bit hs;
    buildModel(r, sgn, int'(c), trim);
    foreach (modelQ[i]) expQ.push_back(modelQ[i]);
    expErr = modelErr;
    startIn = 1'b1; signIn = sgn; commaIn = c; trimIn = trim; addrIn = addr;
    @(posedge clk); #1;
    startIn = 1'b0; signIn = 1'b0; commaIn = 2'd0; trimIn = 1'b0; addrIn = 4'd0;
    hs = 1'b0;
    budget = 0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      if (instrValidOut && bcduReady) begin
        hs = 1'b1;
        checkOutput("bcduInstr", 32'(instrOut), 32'({`BCDU_OP_SHR, addr, 2'b00, 6'd4}));
      end
      @(posedge clk); #1;
      budget++;
    end
    if (!hs) checkOutput("instrHandshakeTimeout", 32'd0, 32'd1);
    for (int k = 0; k < feed; k++) begin
      idx = ND - 1 - k;
      digitIn = r[idx*4 +: 4];
      flagsIn = '0;
      flagsIn[`BCDU_TF] = (idx > 0) && ((r & ((16'h1 << (4*idx)) - 16'h1)) != 16'h0);
      digitValid = 1'b1;
      if (busyStart && k == 1) begin
        startIn = 1'b1;
        signIn = 1'b1;
      end
      @(posedge clk); #1;
      startIn = 1'b0;
      signIn = 1'b0;
    end
    digitValid = 1'b0;
    flagsIn = '0;
  endtask

  task automatic waitDone(input string name);
    int budget;
    bit seen;
    budget = 0;
    seen = 1'b0;
    while (!seen && budget < 300) begin
      @(negedge clk);
      if (doneOut) seen = 1'b1;
      budget++;
    end
    checkOutput({name, "_done"}, 32'(seen), 32'd1);
    checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "_err"}, 32'(errOut), 32'(expErr));
    @(negedge clk);
    checkOutput({name, "_idle"}, 32'(busyOut), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pushLoopback(input logic [SW-1:0] s, input bit toggle);
    int budget;
    bit acc;
    budget = 0;
    acc = 1'b0;
    lbValid = 1'b1;
    lbSym = s;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = lbReadyOut;
      @(posedge clk); #1;
      if (acc) expQ.push_back(s);
      if (toggle) begin
        lbEn = ~lbEn;
        symReady = ~symReady;
      end
      budget++;
    end
    lbValid = 1'b0;
    checkOutput("lbAccepted", 32'(acc), 32'd1);
  endtask

  // Scoreboard: every symbol the consumer takes must be the next expected one.
  always @(negedge clk) begin
    if (rstN && doneOut) doneCount++;
    if (checkEn && rstN && symValidOut && symReady) begin
      if (expQ.size() == 0) checkOutput("spuriousSymbol", {27'd0, symOut}, 32'hFFFF_FFFF);
      else checkOutput("symbol", 32'(symOut), 32'(expQ.pop_front()));
    end
  end

  initial begin
    int doneBefore;
    bit sawInstr;
    rstN = 1'b0; lbEn = 1'b0; lbValid = 1'b0; lbSym = '0;
    startIn = 1'b0; signIn = 1'b0; trimIn = 1'b0; commaIn = 2'd0; addrIn = 4'd0;
    bcduReady = 1'b1; digitIn = 4'd0; digitValid = 1'b0; flagsIn = '0; symReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstSymbol", 32'(symOut), 32'(INVSYM));
    checkOutput("rstSymValid", 32'(symValidOut), 32'd0);
    checkOutput("rstBusy", 32'(busyOut), 32'd0);
    checkOutput("rstDone", 32'(doneOut), 32'd0);
    checkOutput("rstErr", 32'(errOut), 32'd0);
    checkOutput("rstInstrValid", 32'(instrValidOut), 32'd0);
    checkOutput("rstInstr", 32'(instrOut), 32'd0);
    checkOutput("rstLbReady", 32'(lbReadyOut), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    checkEn = 1'b1;

    pinQ = '{5'h11, 5'h12, 5'h10};
    pinModel("pin0120c0", 16'h0120, 1'b0, 0, 1'b0);
    pinQ = '{MINUS, 5'h11, COMMA, 5'h12, 5'h10};
    pinModel("pin0120c2", 16'h0120, 1'b1, 2, 1'b0);
    pinQ = '{MINUS, 5'h11, COMMA, 5'h12};
    pinModel("pin0120c2trim", 16'h0120, 1'b1, 2, 1'b1);
    pinQ = '{5'h11, 5'h12};
    pinModel("pin1200c2trim", 16'h1200, 1'b0, 2, 1'b1);
    pinQ = '{5'h10, COMMA, 5'h10, 5'h10, 5'h15};
    pinModel("pin0005c3", 16'h0005, 1'b0, 3, 1'b0);
    pinQ = '{5'h11, INVSYM, 5'h12, 5'h10};
    pinModel("pin1B20c0", 16'h1B20, 1'b0, 0, 1'b0);

    applyStimulus(16'h0120, 1'b0, 2'd0, 1'b0, 4'h3, ND, 1'b0);
    waitDone("int0120");
    applyStimulus(16'h0120, 1'b1, 2'd2, 1'b0, 4'h1, ND, 1'b0);
    waitDone("neg0120c2");
    applyStimulus(16'h0120, 1'b1, 2'd2, 1'b1, 4'h2, ND, 1'b0);
    waitDone("neg0120c2trim");
    applyStimulus(16'h1200, 1'b0, 2'd2, 1'b1, 4'h4, ND, 1'b0);
    waitDone("1200c2trim");
    applyStimulus(16'h0005, 1'b0, 2'd3, 1'b0, 4'h7, ND, 1'b0);
    waitDone("0005c3");

    symReady = 1'b0;
    applyStimulus(16'h0120, 1'b1, 2'd2, 1'b0, 4'h9, ND, 1'b0);
    doneBefore = doneCount;
    repeat (4) @(negedge clk);
    checkOutput("holdValid", 32'(symValidOut), 32'd1);
    checkOutput("holdHead", 32'(symOut), 32'(MINUS));
    checkOutput("holdBusy", 32'(busyOut), 32'd1);
    checkOutput("holdNoDone", 32'(doneCount), 32'(doneBefore));
    @(posedge clk); #1;
    symReady = 1'b1;
    waitDone("hold");

    doneBefore = doneCount;
    applyStimulus(16'h1B20, 1'b0, 2'd0, 1'b0, 4'h5, ND, 1'b1);
    waitDone("invalid");
    checkOutput("busyStartIgnored", 32'(doneCount - doneBefore), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("errSticky", 32'(errOut), 32'd1);
    @(posedge clk); #1;

    symReady = 1'b0;
    lbEn = 1'b1;
    pushLoopback(5'h03, 1'b0);
    pushLoopback(5'h07, 1'b0);
    lbEn = 1'b0;
    sawInstr = 1'b0;
    fork
      applyStimulus(16'h0005, 1'b0, 2'd3, 1'b0, 4'h6, ND, 1'b0);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("errClearedOnStart", 32'(errOut), 32'd0);
        repeat (5) begin
          if (instrValidOut) sawInstr = 1'b1;
          @(negedge clk);
        end
        checkOutput("instrWithheld", 32'(sawInstr), 32'd0);
        @(posedge clk); #1;
        symReady = 1'b1;
      end
    join
    waitDone("withheld");

    lbEn = 1'b0;
    @(negedge clk);
    checkOutput("lbReadyDisabled", 32'(lbReadyOut), 32'd0);
    @(posedge clk); #1;
    lbEn = 1'b1;
    pushLoopback(5'h03, 1'b1);
    pushLoopback(5'h1A, 1'b1);
    pushLoopback(5'h07, 1'b1);
    lbEn = 1'b0;
    symReady = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("lbForwarded", 32'(expQ.size()), 32'd0);

    symReady = 1'b0;
    applyStimulus(16'h0120, 1'b0, 2'd0, 1'b0, 4'h8, 2, 1'b0);
    @(negedge clk);
    checkOutput("midStreamValid", 32'(symValidOut), 32'd1);
    @(posedge clk); #2;
    checkEn = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(symValidOut), 32'd0);
    checkOutput("asyncRstBusy", 32'(busyOut), 32'd0);
    checkOutput("asyncRstSymbol", 32'(symOut), 32'(INVSYM));
    expQ.delete();
    @(posedge clk); #1;
    rstN = 1'b1;
    symReady = 1'b1;
    checkEn = 1'b1;
    applyStimulus(16'h0120, 1'b0, 2'd0, 1'b0, 4'h3, ND, 1'b0);
    waitDone("afterReset");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
